// File: rtl/mdc_delay_commutator.sv
// Radix-2 MDC delay-commutator stage for the 32-point FFT datapath.
// Upper delay line, 2x2 switch toggling every DELAY beats, lower delay line.
module mdc_delay_commutator #(
    parameter int WIDTH = 9,
    parameter int DELAY = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bypass,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] up_in_re,
    input  logic signed [WIDTH-1:0] up_in_im,
    input  logic signed [WIDTH-1:0] low_in_re,
    input  logic signed [WIDTH-1:0] low_in_im,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] up_out_re,
    output logic signed [WIDTH-1:0] up_out_im,
    output logic signed [WIDTH-1:0] low_out_re,
    output logic signed [WIDTH-1:0] low_out_im
);

    localparam int CW = $clog2(DELAY) + 1;
    localparam int DW = 2 * WIDTH;

    logic [CW-1:0] cnt;
    logic          primed;
    logic          sel;
    logic          beat;

    logic [DW-1:0] up_line  [DELAY];
    logic [DW-1:0] low_line [DELAY];

    logic [DW-1:0] up_pair;
    logic [DW-1:0] low_pair;
    logic [DW-1:0] a_d;
    logic [DW-1:0] low_d;
    logic [DW-1:0] sw_up;
    logic [DW-1:0] sw_low;

    assign beat     = in_valid & ~bypass;
    assign sel      = cnt[CW-1];
    assign up_pair  = {up_in_re, up_in_im};
    assign low_pair = {low_in_re, low_in_im};
    assign a_d      = up_line[DELAY-1];
    assign low_d    = low_line[DELAY-1];

    // 2x2 switch: straight in the first half-frame, crossed in the second
    always_comb begin
        sw_up  = a_d;
        sw_low = low_pair;
        if (sel) begin
            sw_up  = low_pair;
            sw_low = a_d;
        end
    end

    // Frame counter and prime flag, advanced only on delay-path beats
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            primed <= 1'b0;
        end else if (beat) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(DELAY - 1)) begin
                primed <= 1'b1;
            end
        end
    end

    // Valid-gated shift registers; entry DELAY-1 is the oldest sample
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                up_line[i]  <= '0;
                low_line[i] <= '0;
            end
        end else if (beat) begin
            up_line[0]  <= up_pair;
            low_line[0] <= sw_low;
            for (int i = 1; i < DELAY; i++) begin
                up_line[i]  <= up_line[i-1];
                low_line[i] <= low_line[i-1];
            end
        end
    end

    // Output register: bypass passes inputs straight through, else switch/line
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            up_out_re  <= '0;
            up_out_im  <= '0;
            low_out_re <= '0;
            low_out_im <= '0;
        end else begin
            out_valid <= in_valid & (bypass | primed);
            if (in_valid) begin
                if (bypass) begin
                    {up_out_re, up_out_im}   <= up_pair;
                    {low_out_re, low_out_im} <= low_pair;
                end else begin
                    {up_out_re, up_out_im}   <= sw_up;
                    {low_out_re, low_out_im} <= low_d;
                end
            end
        end
    end

endmodule
